// File: rtl/irq_ctrl83_pkg.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl83_defs
// Brief    : Shared widths and FSM state encodings for the irq_ctrl83 block.
// Revision : 1.0 - initial release
// ============================================================================
package irq_ctrl83_defs;

    localparam int NCH = 8;
    localparam int VW  = 3;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ASSERT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/irq_ctrl83_encoder83.sv
`default_nettype none
// ============================================================================
// Module   : encoder83
// Brief    : 8-to-3 priority encoder; the highest asserted input index wins.
// Revision : 1.0 - initial release
// ============================================================================
module encoder83 (
    input  logic       c0,
    input  logic       c1,
    input  logic       c2,
    input  logic       c3,
    input  logic       c4,
    input  logic       c5,
    input  logic       c6,
    input  logic       c7,
    input  logic       en,
    output logic [2:0] a
);

    logic [7:0] w_c;

    assign w_c = {c7, c6, c5, c4, c3, c2, c1, c0};

    // Ascending scan so the last (highest) set bit overwrites lower ones.
    always_comb begin
        a = 3'd0;
        if (en) begin
            for (int i = 0; i < 8; i++) begin
                if (w_c[i]) a = 3'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/irq_ctrl83.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl83
// Brief    : 8-channel interrupt controller with enable mask and irq/ack
//            handshake presenting one frozen vector at a time.
// Revision : 1.0 - initial release
// ============================================================================
module irq_ctrl83
    import irq_ctrl83_defs::*;
#(
    parameter int EDGE = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] req,
    input  logic           mask_we,
    input  logic [NCH-1:0] mask_wdata,
    output logic [NCH-1:0] mask,
    output logic [NCH-1:0] pending,
    output logic           irq,
    output logic [VW-1:0]  vec,
    input  logic           ack
);

    logic [NCH-1:0] r_req_d;
    logic [NCH-1:0] r_pending;
    logic [NCH-1:0] r_mask;
    logic [0:0]     r_state;
    logic           r_irq;
    logic [VW-1:0]  r_vec;

    logic [NCH-1:0] w_set;
    logic [NCH-1:0] w_clr;
    logic [NCH-1:0] w_active;
    logic [VW-1:0]  w_enc_vec;

    generate
        if (EDGE != 0) begin : g_edge
            assign w_set = req & ~r_req_d;
        end else begin : g_level
            assign w_set = req;
        end
    endgenerate

    always_comb begin
        w_clr = '0;
        if (r_state == ASSERT && ack) w_clr[r_vec] = 1'b1;
    end

    assign w_active = r_pending & r_mask;

    encoder83 u_enc (
        .c0 (w_active[0]),
        .c1 (w_active[1]),
        .c2 (w_active[2]),
        .c3 (w_active[3]),
        .c4 (w_active[4]),
        .c5 (w_active[5]),
        .c6 (w_active[6]),
        .c7 (w_active[7]),
        .en (1'b1),
        .a  (w_enc_vec)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req_d   <= '0;
            r_pending <= '0;
            r_mask    <= '0;
            r_state   <= IDLE;
            r_irq     <= 1'b0;
            r_vec     <= '0;
        end else begin
            r_req_d   <= req;
            // Clear first, then set, so a fresh event on the serviced bit survives.
            r_pending <= (r_pending & ~w_clr) | w_set;
            if (mask_we) r_mask <= mask_wdata;
            case (r_state)
                IDLE: begin
                    if (|w_active) begin
                        r_vec   <= w_enc_vec;
                        r_irq   <= 1'b1;
                        r_state <= ASSERT;
                    end
                end
                ASSERT: begin
                    if (ack) begin
                        r_irq   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_irq   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mask    = r_mask;
    assign pending = r_pending;
    assign irq     = r_irq;
    assign vec     = r_vec;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl83.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_ctrl83
// Brief    : Bench for irq_ctrl83 with an edge-mode and a level-mode instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl83;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic [7:0] req_a, req_b;
    logic       ack_a, ack_b;

    logic [7:0] mask_a, mask_b, pend_a, pend_b;
    logic       irq_a, irq_b;
    logic [2:0] vec_a, vec_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    irq_ctrl83 #(.EDGE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .mask_we(mask_we),
        .mask_wdata(mask_wdata), .mask(mask_a), .pending(pend_a),
        .irq(irq_a), .vec(vec_a), .ack(ack_a)
    );

    irq_ctrl83 #(.EDGE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .mask_we(mask_we),
        .mask_wdata(mask_wdata), .mask(mask_b), .pending(pend_b),
        .irq(irq_b), .vec(vec_b), .ack(ack_b)
    );

    // Reference model: index 0 is the edge-mode instance, index 1 level-mode.
    logic [7:0] m_pend[2], m_mask[2], m_reqd[2];
    logic       m_irq[2];
    logic [2:0] m_vec[2];
    bit         m_valid = 1'b0;
    logic [7:0] t_req, t_act, t_np;
    logic       t_ack, t_evt, t_served;
    int         t_win;

    always @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            t_req = (n == 0) ? req_a : req_b;
            t_ack = (n == 0) ? ack_a : ack_b;
            if (!rst_n) begin
                m_pend[n] = 8'h00; m_mask[n] = 8'h00; m_reqd[n] = 8'h00;
                m_irq[n]  = 1'b0;  m_vec[n]  = 3'd0;
            end else begin
                t_act = m_pend[n] & m_mask[n];
                t_win = -1;
                for (int i = 7; i >= 0; i--)
                    if (t_act[i] && t_win < 0) t_win = i;
                for (int i = 0; i < 8; i++) begin
                    t_evt    = (n == 0) ? (t_req[i] && !m_reqd[n][i]) : t_req[i];
                    t_served = m_irq[n] && t_ack && (int'(m_vec[n]) == i);
                    t_np[i]  = t_evt || (m_pend[n][i] && !t_served);
                end
                if (m_irq[n]) begin
                    if (t_ack) m_irq[n] = 1'b0;
                end else if (t_win >= 0) begin
                    m_irq[n] = 1'b1;
                    m_vec[n] = t_win[2:0];
                end
                m_pend[n] = t_np;
                if (mask_we) m_mask[n] = mask_wdata;
                m_reqd[n] = t_req;
            end
        end
        if (!rst_n) m_valid = 1'b1;
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("mdl_a_irq",  {7'd0, irq_a}, {7'd0, m_irq[0]});
            chk("mdl_a_vec",  {5'd0, vec_a}, {5'd0, m_vec[0]});
            chk("mdl_a_pend", pend_a, m_pend[0]);
            chk("mdl_a_mask", mask_a, m_mask[0]);
            chk("mdl_b_irq",  {7'd0, irq_b}, {7'd0, m_irq[1]});
            chk("mdl_b_vec",  {5'd0, vec_b}, {5'd0, m_vec[1]});
            chk("mdl_b_pend", pend_b, m_pend[1]);
            chk("mdl_b_mask", mask_b, m_mask[1]);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr_mask(input logic [7:0] v);
        mask_we = 1'b1; mask_wdata = v;
        step();
        mask_we = 1'b0;
    endtask

    task automatic ack_once_a();
        ack_a = 1'b1; step(); ack_a = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; mask_we = 1'b0; mask_wdata = 8'h00;
        req_a = 8'h00; req_b = 8'h00; ack_a = 1'b0; ack_b = 1'b0;
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("rst_mask", mask_a, 8'h00);
            chk("rst_pend", pend_a, 8'h00);
            chk("rst_irq",  {7'd0, irq_a}, 8'h00);
            chk("rst_vec",  {5'd0, vec_a}, 8'h00);
        end

        // Single edge request on channel 3
        wr_mask(8'hFF);
        chk("mask_ff", mask_a, 8'hFF);
        req_a = 8'h08; step(); req_a = 8'h00;
        chk("single_pend", pend_a, 8'h08);
        chk("single_irq0", {7'd0, irq_a}, 8'h00);
        step();
        chk("single_irq", {7'd0, irq_a}, 8'h01);
        chk("single_vec", {5'd0, vec_a}, 8'h03);
        ack_once_a();
        chk("single_ack_irq", {7'd0, irq_a}, 8'h00);
        chk("single_ack_pend", pend_a, 8'h00);

        // Priority and no preemption
        req_a = 8'h24; step(); req_a = 8'h00;
        step();
        chk("prio_vec5", {5'd0, vec_a}, 8'h05);
        req_a = 8'h80; step(); req_a = 8'h00;
        chk("nopre_vec", {5'd0, vec_a}, 8'h05);
        chk("nopre_pend", pend_a, 8'hA4);
        ack_once_a();
        chk("gap1_irq", {7'd0, irq_a}, 8'h00);
        chk("gap1_pend", pend_a, 8'h84);
        step();
        chk("vec7_irq", {7'd0, irq_a}, 8'h01);
        chk("vec7", {5'd0, vec_a}, 8'h07);
        ack_once_a();
        chk("gap2_irq", {7'd0, irq_a}, 8'h00);
        step();
        chk("vec2", {5'd0, vec_a}, 8'h02);
        ack_once_a();
        chk("prio_done_pend", pend_a, 8'h00);

        // Masking
        wr_mask(8'hF0);
        req_a = 8'h02; step(); req_a = 8'h00;
        chk("masked_pend", pend_a, 8'h02);
        step();
        chk("masked_irq", {7'd0, irq_a}, 8'h00);
        wr_mask(8'hFF);
        chk("unmask_irq0", {7'd0, irq_a}, 8'h00);
        step();
        chk("unmask_irq", {7'd0, irq_a}, 8'h01);
        chk("unmask_vec", {5'd0, vec_a}, 8'h01);
        ack_once_a();
        step();

        // Set/clear collision on channel 4
        req_a = 8'h10; step(); req_a = 8'h00;
        step();
        chk("coll_vec", {5'd0, vec_a}, 8'h04);
        req_a = 8'h10; ack_a = 1'b1; step(); req_a = 8'h00; ack_a = 1'b0;
        chk("coll_pend", pend_a, 8'h10);
        chk("coll_irq0", {7'd0, irq_a}, 8'h00);
        step();
        chk("coll_reirq", {7'd0, irq_a}, 8'h01);
        chk("coll_revec", {5'd0, vec_a}, 8'h04);
        ack_once_a();
        step();
        chk("coll_done", pend_a, 8'h00);

        // Level mode: held source keeps re-interrupting
        req_b = 8'h40; step(); step();
        chk("lvl_irq", {7'd0, irq_b}, 8'h01);
        chk("lvl_vec", {5'd0, vec_b}, 8'h06);
        for (int k = 0; k < 2; k++) begin
            ack_b = 1'b1; step(); ack_b = 1'b0;
            chk("lvl_gap_irq", {7'd0, irq_b}, 8'h00);
            chk("lvl_gap_pend", pend_b, 8'h40);
            step();
            chk("lvl_reirq", {7'd0, irq_b}, 8'h01);
            chk("lvl_revec", {5'd0, vec_b}, 8'h06);
        end
        req_b = 8'h00; ack_b = 1'b1; step(); ack_b = 1'b0;
        chk("lvl_drop_pend", pend_b, 8'h00);
        step();
        chk("lvl_drop_irq", {7'd0, irq_b}, 8'h00);

        // Reset while an interrupt is outstanding
        req_b = 8'h40; step(); step();
        chk("mid_irq", {7'd0, irq_b}, 8'h01);
        rst_n = 1'b0; step();
        chk("mid_rst_irq",  {7'd0, irq_b}, 8'h00);
        chk("mid_rst_pend", pend_b, 8'h00);
        chk("mid_rst_mask", mask_b, 8'h00);
        rst_n = 1'b1; req_b = 8'h00;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
